// File: rtl/ldlt_tri_solve_pkg.sv
// rtl/ldlt_tri_solve_pkg.sv - shared constants, state type and fixed-point helpers for ldlt_tri_solve
package ldlt_tri_solve_pkg;

   localparam int DEF_DATA_LEN = 34;
   localparam int DEF_FRACTION = 16;
   localparam int DEF_NODE_NUM = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FWD,
      S_DIV,
      S_BWD,
      S_OUT
   } state_t;

   function automatic int mat_n(input int node_num);
      return 6 * node_num;
   endfunction

   function automatic int tri_size(input int n);
      return n * (n + 1) / 2;
   endfunction

   // Position of L[i][j] (or D[i] when j == i) in the row-major lower-triangle stream
   function automatic int tri_index(input int i, input int j);
      return i * (i + 1) / 2 + j;
   endfunction

   // Clamp a wide signed value into a width-bit two's complement range
   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Full-precision signed product, arithmetic shift right (floor) by frac
   function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int frac);
      logic signed [127:0] p;
      p = (128'(a) * 128'(b)) >>> frac;
      return p[63:0];
   endfunction

endpackage

// File: rtl/ldlt_tri_solve_fx_div.sv
// rtl/ldlt_tri_solve_fx_div.sv - sequential restoring signed divider computing (num<<FRACTION)/den
module ldlt_tri_solve_fx_div
   import ldlt_tri_solve_pkg::*;
#(
   parameter int DATA_LEN = DEF_DATA_LEN,
   parameter int FRACTION = DEF_FRACTION
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic signed [DATA_LEN-1:0] num,
   input  logic signed [DATA_LEN-1:0] den,
   output logic                       done,
   output logic signed [DATA_LEN-1:0] quo,
   output logic                       dz
);

   // One load cycle, QW shift/subtract cycles, one result cycle: DATA_LEN+FRACTION+2 total
   localparam int QW = DATA_LEN + FRACTION;
   localparam int CW = $clog2(QW + 1);
   localparam logic signed [DATA_LEN-1:0] POS_MAX = {1'b0, {(DATA_LEN - 1){1'b1}}};

   logic [DATA_LEN-1:0] rem;
   logic [DATA_LEN-1:0] dmag;
   logic [DATA_LEN-1:0] nmag_in;
   logic [DATA_LEN-1:0] dmag_in;
   logic [QW-1:0]       q;
   logic [DATA_LEN:0]   shifted;
   logic [DATA_LEN:0]   trial;
   logic [CW-1:0]       cnt;
   logic                busy;
   logic                neg;
   logic                num_neg;
   logic                zero;
   logic signed [63:0]  q_signed;

   // Magnitudes, trial subtraction and sign/saturation of the final quotient
   always_comb begin
      nmag_in  = num[DATA_LEN-1] ? -num : num;
      dmag_in  = den[DATA_LEN-1] ? -den : den;
      shifted  = {rem, q[QW-1]};
      trial    = shifted - {1'b0, dmag};
      q_signed = neg ? -64'(q) : 64'(q);
      done     = busy && (cnt == CW'(QW));
      dz       = zero;
      if (zero) begin
         quo = num_neg ? -POS_MAX : POS_MAX;
      end else begin
         quo = DATA_LEN'(sat(q_signed, DATA_LEN));
      end
   end

   // Load operands on start, then one restoring step per cycle until the quotient is complete
   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         cnt     <= '0;
         rem     <= '0;
         q       <= '0;
         dmag    <= '0;
         neg     <= 1'b0;
         num_neg <= 1'b0;
         zero    <= 1'b0;
      end else if (start) begin
         busy    <= 1'b1;
         cnt     <= '0;
         rem     <= '0;
         q       <= {nmag_in, {FRACTION{1'b0}}};
         dmag    <= dmag_in;
         neg     <= num[DATA_LEN-1] ^ den[DATA_LEN-1];
         num_neg <= num[DATA_LEN-1];
         zero    <= (den == '0);
      end else if (busy) begin
         if (cnt == CW'(QW)) begin
            busy <= 1'b0;
         end else begin
            if (!trial[DATA_LEN]) begin
               rem <= trial[DATA_LEN-1:0];
               q   <= {q[QW-2:0], 1'b1};
            end else begin
               rem <= shifted[DATA_LEN-1:0];
               q   <= {q[QW-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ldlt_tri_solve.sv
// rtl/ldlt_tri_solve.sv - solves L*D*L^T x = b from a packed L/D stream and a b stream
module ldlt_tri_solve
   import ldlt_tri_solve_pkg::*;
#(
   parameter int DATA_LEN = DEF_DATA_LEN,
   parameter int FRACTION = DEF_FRACTION,
   parameter int NODE_NUM = DEF_NODE_NUM
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_ld_valid,
   input  logic [DATA_LEN-1:0] i_ld_data,
   input  logic                i_b_valid,
   input  logic [DATA_LEN-1:0] i_b_data,
   output logic                o_ready,
   output logic                o_valid,
   output logic [DATA_LEN-1:0] o_data,
   output logic                o_err
);

   localparam int N      = mat_n(NODE_NUM);
   localparam int L_SIZE = tri_size(N);
   localparam int ACC_W  = DATA_LEN + 8;
   localparam int IW     = $clog2(N);
   localparam int KW     = $clog2(L_SIZE);
   localparam int LCW    = $clog2(L_SIZE + 1);
   localparam int BCW    = $clog2(N + 1);

   state_t state, state_next;

   // b, y, z and x share one vector, overwritten in place as the solve proceeds
   logic signed [DATA_LEN-1:0] ld_mem [L_SIZE];
   logic signed [DATA_LEN-1:0] vec    [N];

   logic [LCW-1:0]             ld_cnt;
   logic [BCW-1:0]             b_cnt;
   logic [IW-1:0]              i_r;
   logic [IW-1:0]              j_r;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_in;
   logic signed [ACC_W-1:0]    prod;
   logic [KW-1:0]              lidx;
   logic [KW-1:0]              diag_idx;
   logic                       first;
   logic                       row_last;
   logic                       ld_acc;
   logic                       b_acc;
   logic                       div_busy;
   logic                       div_start;
   logic                       div_done;
   logic                       div_dz;
   logic signed [DATA_LEN-1:0] div_quo;

   assign o_ready   = !rst && ((state == S_IDLE) || (state == S_LOAD));
   assign ld_acc    = i_ld_valid && o_ready;
   assign b_acc     = i_b_valid && o_ready;
   assign div_start = (state == S_DIV) && !div_busy;
   assign diag_idx  = KW'(tri_index(int'(i_r), int'(i_r)));

   ldlt_tri_solve_fx_div #(
      .DATA_LEN (DATA_LEN),
      .FRACTION (FRACTION)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .num   (vec[i_r]),
      .den   (ld_mem[diag_idx]),
      .done  (div_done),
      .quo   (div_quo),
      .dz    (div_dz)
   );

   // Shared MAC for both substitutions: forward walks row i over j=0..i, backward walks column i over j=N-1..i
   always_comb begin
      first    = (state == S_FWD) ? (j_r == '0) : (j_r == IW'(N - 1));
      row_last = (j_r == i_r);
      lidx     = (state == S_FWD) ? KW'(tri_index(int'(i_r), int'(j_r)))
                                  : KW'(tri_index(int'(j_r), int'(i_r)));
      acc_in   = first ? ACC_W'(vec[i_r]) : acc;
      prod     = ACC_W'(fx_mul(64'(ld_mem[lidx]), 64'(vec[j_r]), FRACTION));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state logic; every phase length is fixed so latency never depends on data
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (ld_acc || b_acc) state_next = S_LOAD;
         S_LOAD: if (ld_cnt == LCW'(L_SIZE) && b_cnt == BCW'(N)) state_next = S_FWD;
         S_FWD:  if (row_last && i_r == IW'(N - 1)) state_next = S_DIV;
         S_DIV:  if (div_done && i_r == IW'(N - 1)) state_next = S_BWD;
         S_BWD:  if (row_last && i_r == '0) state_next = S_OUT;
         S_OUT:  if (i_r == IW'(N - 1)) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Capture, substitution, division sequencing and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_cnt   <= '0;
         b_cnt    <= '0;
         i_r      <= '0;
         j_r      <= '0;
         acc      <= '0;
         div_busy <= 1'b0;
         o_valid  <= 1'b0;
         o_data   <= '0;
         o_err    <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (ld_acc || b_acc) o_err <= 1'b0;
         if (ld_acc && ld_cnt < LCW'(L_SIZE)) begin
            ld_mem[KW'(ld_cnt)] <= i_ld_data;
            ld_cnt              <= ld_cnt + 1'b1;
         end
         if (b_acc && b_cnt < BCW'(N)) begin
            vec[IW'(b_cnt)] <= i_b_data;
            b_cnt           <= b_cnt + 1'b1;
         end
         case (state)
            S_LOAD: begin
               if (state_next == S_FWD) begin
                  ld_cnt <= '0;
                  b_cnt  <= '0;
                  i_r    <= '0;
                  j_r    <= '0;
               end
            end
            S_FWD, S_BWD: begin
               if (row_last) begin
                  vec[i_r] <= DATA_LEN'(sat(64'(acc_in), DATA_LEN));
                  if (state == S_FWD) begin
                     j_r <= '0;
                     i_r <= (i_r == IW'(N - 1)) ? '0 : i_r + 1'b1;
                  end else if (i_r != '0) begin
                     i_r <= i_r - 1'b1;
                     j_r <= IW'(N - 1);
                  end
               end else begin
                  acc <= acc_in - prod;
                  j_r <= (state == S_FWD) ? j_r + 1'b1 : j_r - 1'b1;
               end
            end
            S_DIV: begin
               if (!div_busy) begin
                  div_busy <= 1'b1;
               end else if (div_done) begin
                  div_busy <= 1'b0;
                  vec[i_r] <= div_quo;
                  o_err    <= o_err | div_dz;
                  if (i_r == IW'(N - 1)) begin
                     j_r <= IW'(N - 1);
                  end else begin
                     i_r <= i_r + 1'b1;
                  end
               end
            end
            S_OUT: begin
               o_valid <= 1'b1;
               o_data  <= vec[i_r];
               i_r     <= (i_r == IW'(N - 1)) ? '0 : i_r + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
